// File: rtl/gfx_bus_responder.sv
// Responder side of the graphics-unit bus: grants one master at a time and runs its
// memory cycles against a fixed-latency memory port, returning a one-cycle ack.
module gfx_bus_responder #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  blit_breq,
    input  logic        gpu_breq,
    input  logic        dma_breq,
    input  logic        lock,
    input  logic        mreq,
    input  logic        read,
    input  logic [23:0] a,
    input  logic [3:0]  width,
    input  logic [63:0] wdata,
    output logic        blit_back,
    output logic        gpu_back,
    output logic        dma_back,
    output logic        ack,
    output logic [63:0] data,
    output logic        mem_sel,
    output logic        mem_we,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned CW = 4;
    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ACCESS,
        S_ACK,
        S_TURN
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            rd_q;
    logic            legal_q;

    logic            owner_breq_c;
    logic            legal_c;
    logic [BW-1:0]   be_c;

    // Current owner still asking for the bus; both blit request bits count for the blitter.
    assign owner_breq_c = (blit_back & (|blit_breq)) | (gpu_back & gpu_breq) | (dma_back & dma_breq);
    assign legal_c      = (width != 4'b0000) && ((width & (width - 4'b0001)) == 4'b0000);

    // Lane mask for the access, address aligned down to the access size.
    always_comb begin
        be_c = '0;
        case (width)
            4'b0001: be_c = 8'h01 << a[2:0];
            4'b0010: be_c = 8'h03 << {a[2:1], 1'b0};
            4'b0100: be_c = 8'h0F << {a[2], 2'b00};
            4'b1000: be_c = 8'hFF;
            default: be_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rd_q      <= 1'b0;
            legal_q   <= 1'b0;
            blit_back <= 1'b0;
            gpu_back  <= 1'b0;
            dma_back  <= 1'b0;
            ack       <= 1'b0;
            data      <= '0;
            mem_sel   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dma_breq) begin
                        dma_back <= 1'b1;
                        state    <= S_GRANT;
                    end else if (blit_breq[1]) begin
                        blit_back <= 1'b1;
                        state     <= S_GRANT;
                    end else if (gpu_breq) begin
                        gpu_back <= 1'b1;
                        state    <= S_GRANT;
                    end else if (blit_breq[0]) begin
                        blit_back <= 1'b1;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // A pending mreq takes precedence over releasing the grant.
                    if (mreq) begin
                        rd_q      <= read;
                        legal_q   <= legal_c;
                        mem_sel   <= 1'b1;
                        mem_we    <= ~read & legal_c;
                        mem_addr  <= a[23:3];
                        mem_be    <= be_c;
                        mem_wdata <= wdata;
                        cnt       <= CW'(WAIT_STATES);
                        state     <= S_ACCESS;
                    end else if (!owner_breq_c && !lock) begin
                        blit_back <= 1'b0;
                        gpu_back  <= 1'b0;
                        dma_back  <= 1'b0;
                        state     <= S_TURN;
                    end
                end
                S_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        mem_sel <= 1'b0;
                        mem_we  <= 1'b0;
                        ack     <= 1'b1;
                        if (rd_q) begin
                            data <= legal_q ? mem_rdata : '0;
                        end
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    state <= S_GRANT;
                end
                S_TURN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_bus_responder.sv
// Bench for gfx_bus_responder: directed and randomized bus scenarios checked against
// lane, priority and latency rules computed directly in the bench.
module tb_gfx_bus_responder;

    localparam int unsigned WS = 2;

    logic        clk;
    logic        reset_n;
    logic [1:0]  blit_breq;
    logic        gpu_breq;
    logic        dma_breq;
    logic        lock;
    logic        mreq;
    logic        read;
    logic [23:0] a;
    logic [3:0]  width;
    logic [63:0] wdata;
    logic        blit_back;
    logic        gpu_back;
    logic        dma_back;
    logic        ack;
    logic [63:0] data;
    logic        mem_sel;
    logic        mem_we;
    logic [20:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int ntests;
    int nfail;
    int cyc;
    int last_ack_cyc;
    logic [63:0] exp_data;

    gfx_bus_responder #(.WAIT_STATES(WS)) dut (
        .clk(clk), .reset_n(reset_n),
        .blit_breq(blit_breq), .gpu_breq(gpu_breq), .dma_breq(dma_breq),
        .lock(lock), .mreq(mreq), .read(read), .a(a), .width(width), .wdata(wdata),
        .blit_back(blit_back), .gpu_back(gpu_back), .dma_back(dma_back),
        .ack(ack), .data(data),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected lanes: S-byte window starting at the offset aligned down to S.
    function automatic logic [7:0] exp_be(input logic [23:0] addr, input logic [3:0] w);
        int s;
        int base;
        logic [7:0] r;
        case (w)
            4'b0001: s = 1;
            4'b0010: s = 2;
            4'b0100: s = 4;
            4'b1000: s = 8;
            default: s = 0;
        endcase
        r = '0;
        if (s != 0) begin
            base = (int'(addr[2:0]) / s) * s;
            for (int i = 0; i < 8; i++) if (i >= base && i < base + s) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic is_legal(input logic [3:0] w);
        return (w == 4'b0001) || (w == 4'b0010) || (w == 4'b0100) || (w == 4'b1000);
    endfunction

    // Issues one mreq from GRANT and follows it to the return to GRANT.
    task automatic access(input logic rd, input logic [23:0] addr, input logic [3:0] w,
                          input logic [63:0] wd, input logic [63:0] rdat,
                          output int lat, output logic [7:0] be_o, output logic we_o,
                          output logic [20:0] ad_o, output logic [63:0] wd_o,
                          output logic sel_ok, output logic [63:0] data_o, output logic pulse_ok);
        read = rd; a = addr; width = w; wdata = wd; mem_rdata = rdat; mreq = 1'b1;
        tick();
        mreq = 1'b0; read = 1'b0; a = '0; width = '0; wdata = '0;
        be_o = mem_be; we_o = mem_we; ad_o = mem_addr; wd_o = mem_wdata; sel_ok = mem_sel;
        lat = 0;
        while (ack !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (ack !== 1'b1) sel_ok = sel_ok & mem_sel;
        end
        sel_ok = sel_ok & ~mem_sel;
        data_o = data;
        last_ack_cyc = cyc;
        if (ack === 1'b1 && rd) exp_data = is_legal(w) ? rdat : 64'h0;
        tick();
        pulse_ok = (ack === 1'b0);
    endtask

    task automatic release_all();
        blit_breq = '0; gpu_breq = 1'b0; dma_breq = 1'b0; lock = 1'b0; mreq = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        ntests++;
        if ({blit_back, gpu_back, dma_back, ack, mem_sel, mem_we} !== 6'b0) begin
            nfail++;
            $display("FAIL %s ctrl: got %b expected 000000", tag,
                     {blit_back, gpu_back, dma_back, ack, mem_sel, mem_we});
        end
        ntests++;
        if ({data, mem_wdata, mem_addr, mem_be} !== '0) begin
            nfail++;
            $display("FAIL %s busses: got data=%h wdata=%h addr=%h be=%h expected all 0",
                     tag, data, mem_wdata, mem_addr, mem_be);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        blit_breq = '0; gpu_breq = 1'b0; dma_breq = 1'b0; lock = 1'b0; mreq = 1'b0;
        read = 1'b0; a = '0; width = '0; wdata = '0; mem_rdata = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();
        check_all_zero("after_reset_idle");
    endtask

    task automatic test_priority();
        logic [2:0] expg;
        logic [3:0] req;
        gpu_breq = 1'b1; blit_breq = 2'b01;
        tick();
        ntests++;
        if ({blit_back, gpu_back, dma_back} !== 3'b010) begin
            nfail++; $display("FAIL prio_gpu: got %b expected 010", {blit_back, gpu_back, dma_back});
        end
        gpu_breq = 1'b0;
        tick();
        ntests++;
        if ({blit_back, gpu_back, dma_back} !== 3'b000) begin
            nfail++; $display("FAIL turn_gap1: got %b expected 000", {blit_back, gpu_back, dma_back});
        end
        tick();
        ntests++;
        if ({blit_back, gpu_back, dma_back} !== 3'b000) begin
            nfail++; $display("FAIL turn_gap2: got %b expected 000", {blit_back, gpu_back, dma_back});
        end
        tick();
        ntests++;
        if ({blit_back, gpu_back, dma_back} !== 3'b100) begin
            nfail++; $display("FAIL blit_after_turn: got %b expected 100", {blit_back, gpu_back, dma_back});
        end
        release_all();
        // Random request mixes: dma > blit[1] > gpu > blit[0].
        for (int k = 0; k < 10; k++) begin
            req = 4'($urandom_range(1, 15));
            {dma_breq, blit_breq[1], gpu_breq, blit_breq[0]} = req;
            if (req[3])      expg = 3'b001;
            else if (req[2]) expg = 3'b100;
            else if (req[1]) expg = 3'b010;
            else             expg = 3'b100;
            tick();
            ntests++;
            if ({blit_back, gpu_back, dma_back} !== expg) begin
                nfail++;
                $display("FAIL prio_rand req=%b: got %b expected %b", req, {blit_back, gpu_back, dma_back}, expg);
            end
            release_all();
        end
    endtask

    task automatic test_read();
        int lat; logic [7:0] be; logic we; logic [20:0] ad; logic [63:0] wd; logic sel; logic [63:0] d; logic pl;
        logic [23:0] addr; logic [3:0] w; logic [63:0] rd;
        gpu_breq = 1'b1;
        tick();
        access(1'b1, 24'h000010, 4'b0100, 64'h0, 64'h1122334455667788, lat, be, we, ad, wd, sel, d, pl);
        // Ack occupies cycle N+2+WS, i.e. it is visible just after edge N+1+WS.
        ntests++;
        if (lat != WS + 1) begin nfail++; $display("FAIL read_latency: got %0d expected %0d", lat, WS + 1); end
        ntests++;
        if (d !== 64'h1122334455667788) begin nfail++; $display("FAIL read_data: got %h expected 1122334455667788", d); end
        ntests++;
        if ({be, we, ad, sel, pl} !== {8'h0F, 1'b0, 21'h2, 1'b1, 1'b1}) begin
            nfail++; $display("FAIL read_port: got be=%h we=%b addr=%h sel=%b pulse=%b expected 0f 0 2 1 1", be, we, ad, sel, pl);
        end
        for (int k = 0; k < 8; k++) begin
            addr = 24'($urandom); w = 4'(1 << $urandom_range(0, 3)); rd = {$urandom, $urandom};
            access(1'b1, addr, w, 64'h0, rd, lat, be, we, ad, wd, sel, d, pl);
            ntests++;
            if ({d, be, ad, we, lat} !== {rd, exp_be(addr, w), addr[23:3], 1'b0, WS + 1}) begin
                nfail++;
                $display("FAIL read_rand a=%h w=%b: got d=%h be=%h addr=%h we=%b lat=%0d expected %h %h %h 0 %0d",
                         addr, w, d, be, ad, we, lat, rd, exp_be(addr, w), addr[23:3], WS + 1);
            end
        end
    endtask

    task automatic test_write();
        int lat; logic [7:0] be; logic we; logic [20:0] ad; logic [63:0] wd; logic sel; logic [63:0] d; logic pl;
        logic [23:0] addr; logic [3:0] w; logic [63:0] wv;
        access(1'b0, 24'h000005, 4'b0001, 64'hAB << 40, 64'hFFFF, lat, be, we, ad, wd, sel, d, pl);
        ntests++;
        if ({be, we, ad, wd} !== {8'h20, 1'b1, 21'h0, 64'hAB << 40}) begin
            nfail++; $display("FAIL byte_write: got be=%h we=%b addr=%h wdata=%h expected 20 1 0 %h", be, we, ad, wd, 64'hAB << 40);
        end
        ntests++;
        if (d !== exp_data) begin nfail++; $display("FAIL write_data_held: got %h expected %h", d, exp_data); end
        access(1'b0, 24'h00000E, 4'b0100, 64'h0, 64'h0, lat, be, we, ad, wd, sel, d, pl);
        ntests++;
        if (be !== 8'hF0) begin nfail++; $display("FAIL word_write_be: got %h expected f0", be); end
        for (int k = 0; k < 8; k++) begin
            addr = 24'($urandom); w = 4'(1 << $urandom_range(0, 3)); wv = {$urandom, $urandom};
            access(1'b0, addr, w, wv, {$urandom, $urandom}, lat, be, we, ad, wd, sel, d, pl);
            ntests++;
            if ({be, we, ad, wd, d, sel} !== {exp_be(addr, w), 1'b1, addr[23:3], wv, exp_data, 1'b1}) begin
                nfail++;
                $display("FAIL write_rand a=%h w=%b: got be=%h we=%b addr=%h wdata=%h data=%h sel=%b",
                         addr, w, be, we, ad, wd, d, sel);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] be; logic we; logic [20:0] ad; logic [63:0] wd; logic sel; logic [63:0] d; logic pl;
        int first;
        dma_breq = 1'b1;
        access(1'b1, 24'h000100, 4'b1000, 64'h0, 64'hCAFE, lat, be, we, ad, wd, sel, d, pl);
        first = last_ack_cyc;
        access(1'b0, 24'h000108, 4'b1000, 64'h5, 64'h0, lat, be, we, ad, wd, sel, d, pl);
        ntests++;
        if (last_ack_cyc - first != int'(WS) + 3) begin
            nfail++; $display("FAIL back_to_back: got %0d expected %0d", last_ack_cyc - first, WS + 3);
        end
        ntests++;
        if ({gpu_back, dma_back} !== 2'b10) begin
            nfail++; $display("FAIL no_preempt: got %b expected 10", {gpu_back, dma_back});
        end
        dma_breq = 1'b0;
    endtask

    task automatic test_lock();
        logic held;
        gpu_breq = 1'b0; lock = 1'b1; dma_breq = 1'b1;
        held = 1'b1;
        repeat (3) begin
            tick();
            held = held & gpu_back & ~dma_back;
        end
        ntests++;
        if (held !== 1'b1) begin nfail++; $display("FAIL lock_hold: got %b expected 1", held); end
        lock = 1'b0;
        tick();
        tick();
        ntests++;
        if ({blit_back, gpu_back, dma_back} !== 3'b000) begin
            nfail++; $display("FAIL lock_turn: got %b expected 000", {blit_back, gpu_back, dma_back});
        end
        tick();
        ntests++;
        if ({blit_back, gpu_back, dma_back} !== 3'b001) begin
            nfail++; $display("FAIL lock_dma: got %b expected 001", {blit_back, gpu_back, dma_back});
        end
    endtask

    task automatic test_illegal();
        int lat; logic [7:0] be; logic we; logic [20:0] ad; logic [63:0] wd; logic sel; logic [63:0] d; logic pl;
        access(1'b0, 24'h000040, 4'b0011, 64'h77, 64'h0, lat, be, we, ad, wd, sel, d, pl);
        ntests++;
        if ({lat, be, we} !== {WS + 1, 8'h00, 1'b0}) begin
            nfail++; $display("FAIL illegal_write: got lat=%0d be=%h we=%b expected %0d 00 0", lat, be, we, WS + 1);
        end
        access(1'b1, 24'h000048, 4'b0000, 64'h0, 64'hDEADBEEF, lat, be, we, ad, wd, sel, d, pl);
        ntests++;
        if ({d, be} !== {64'h0, 8'h00}) begin
            nfail++; $display("FAIL illegal_read: got data=%h be=%h expected 0 00", d, be);
        end
    endtask

    task automatic test_drop_with_mreq();
        int lat; logic [7:0] be; logic we; logic [20:0] ad; logic [63:0] wd; logic sel; logic [63:0] d; logic pl;
        dma_breq = 1'b0;
        access(1'b1, 24'h000200, 4'b0010, 64'h0, 64'h1234, lat, be, we, ad, wd, sel, d, pl);
        ntests++;
        if ({dma_back, lat} !== {1'b1, WS + 1}) begin
            nfail++; $display("FAIL drop_mreq_runs: got grant=%b lat=%0d expected 1 %0d", dma_back, lat, WS + 1);
        end
        tick();
        ntests++;
        if (dma_back !== 1'b0) begin nfail++; $display("FAIL drop_after_ack: got %b expected 0", dma_back); end
        release_all();
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        gpu_breq = 1'b1;
        tick();
        read = 1'b0; a = 24'h000123; width = 4'b1000; wdata = 64'h99; mreq = 1'b1;
        tick();
        mreq = 1'b0; gpu_breq = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_access");
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | ack;
        end
        ntests++;
        if (seen !== 1'b0) begin nfail++; $display("FAIL no_ack_after_reset: got %b expected 0", seen); end
    endtask

    initial begin
        ntests = 0; nfail = 0; cyc = 0; last_ack_cyc = 0; exp_data = '0;
        test_reset();
        test_priority();
        test_read();
        test_write();
        test_back_to_back();
        release_all();
        gpu_breq = 1'b1;
        tick();
        test_lock();
        test_illegal();
        test_drop_with_mreq();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
